// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, status bit positions, commit FSM encoding.
// The SQUASH state exists only when BRANCH_SQUASH_EN is defined.
package cpu_pkg;

  localparam logic [4:0] OP_LD  = 5'h01;
  localparam logic [4:0] OP_ST  = 5'h02;
  localparam logic [4:0] OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_SL  = 5'h09;
  localparam logic [4:0] OP_SR  = 5'h0A;
  localparam logic [4:0] OP_BZ  = 5'h10;
  localparam logic [4:0] OP_BNZ = 5'h11;
  localparam logic [4:0] OP_BRA = 5'h12;

  localparam int unsigned ST_Z     = 0;
  localparam int unsigned ST_N     = 1;
  localparam int unsigned ST_C     = 2;
  localparam int unsigned ST_V     = 3;
  localparam int unsigned ST_S     = 4;
  localparam int unsigned ST_H     = 5;
  localparam int unsigned STATUS_W = 6;

`ifdef BRANCH_SQUASH_EN
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WB_WAIT = 2'd1,
    SQUASH  = 2'd2
  } commit_state_e;
`else
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WB_WAIT = 2'd1
  } commit_state_e;
`endif

  function automatic logic op_sets_flags(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_SR);
  endfunction

  function automatic logic op_writes_back(input logic [4:0] op);
    return (op == OP_LD) || op_sets_flags(op);
  endfunction

endpackage

// File: rtl/commit_status_reg.sv
// Status flag register: captures ALU flags for flag-setting ops, derives S = N ^ V.
module commit_status_reg
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                commit,
  input  logic [4:0]          op,
  input  logic                alu_z,
  input  logic                alu_n,
  input  logic                alu_c,
  input  logic                alu_v,
  input  logic                alu_h,
  output logic [STATUS_W-1:0] status
);

  // {h, v, c, n, z}
  logic [4:0] flags_q;
  logic       upd;

  assign upd = commit && op_sets_flags(op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (upd) begin
      flags_q <= {alu_h, alu_v, alu_c, alu_n, alu_z};
    end
  end

  always_comb begin
    status       = '0;
    status[ST_Z] = flags_q[0];
    status[ST_N] = flags_q[1];
    status[ST_C] = flags_q[2];
    status[ST_V] = flags_q[3];
    status[ST_S] = flags_q[1] ^ flags_q[3];
    status[ST_H] = flags_q[4];
  end

endmodule

// File: rtl/commit_stage.sv
// Commit stage: status feedback, one-entry writeback register and program counter.
// Define BRANCH_SQUASH_EN to discard the op accepted right after a taken branch.
module commit_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     RADDR_W  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          op,
  input  logic [31:0]         alu_out,
  input  logic                alu_z,
  input  logic                alu_n,
  input  logic                alu_c,
  input  logic                alu_v,
  input  logic                alu_h,
  input  logic                alu_branch,
  input  logic [RADDR_W-1:0]  rd_addr,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [RADDR_W-1:0]  wb_addr,
  output logic [31:0]         wb_data,
  output logic [STATUS_W-1:0] status,
  output logic [PC_W-1:0]     pc,
  output logic                pc_redirect
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  commit_state_e state_q, state_d;
  logic          accept;
  logic          commit;

  assign accept = in_valid && in_ready;

  // An accepted op only takes effect outside the post-branch squash slot.
  always_comb begin
    in_ready = (state_q != WB_WAIT) && (!wb_valid || wb_ready);
    commit   = accept;
`ifdef BRANCH_SQUASH_EN
    if (state_q == SQUASH) begin
      in_ready = 1'b1;
      commit   = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (wb_valid && !wb_ready) state_d = WB_WAIT;
`ifdef BRANCH_SQUASH_EN
        if (commit && alu_branch) state_d = SQUASH;
`endif
      end
      WB_WAIT: if (wb_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pc_redirect <= 1'b0;
    end else begin
      pc_redirect <= commit && alu_branch;
      if (commit) begin
        pc <= alu_branch ? alu_out[PC_W-1:0] : pc + PC_ONE;
      end
    end
  end

  // A new writeback op reloads the entry in the same cycle the old one drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (commit && op_writes_back(op)) begin
      wb_valid <= 1'b1;
      wb_addr  <= rd_addr;
      wb_data  <= alu_out;
    end else if (wb_valid && wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  commit_status_reg u_status (
    .clk    (clk),
    .rst_n  (rst_n),
    .commit (commit),
    .op     (op),
    .alu_z  (alu_z),
    .alu_n  (alu_n),
    .alu_c  (alu_c),
    .alu_v  (alu_v),
    .alu_h  (alu_h),
    .status (status)
  );

endmodule
